// File: rtl/twisted_ring_counter.sv
// Johnson (twisted-ring) or plain ring shift counter with up/down step, load, decode and wrap pulse.
// Optional macro SELF_CORRECT_EN: an illegal register value is forced back to the seed on the next edge.
module twisted_ring_counter #(
    parameter int WIDTH = 4,
    parameter int RING  = 0,
    localparam int STATES = (RING != 0) ? WIDTH : 2 * WIDTH,
    localparam int IW     = $clog2(STATES)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Up,
    input  logic              Load,
    input  logic [WIDTH-1:0]  Load_value,
    output logic [WIDTH-1:0]  Count_out,
    output logic [STATES-1:0] Decode_out,
    output logic [IW-1:0]     Index_out,
    output logic              Wrap,
    output logic              Invalid
);

    localparam logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, (RING != 0)};
    localparam logic [IW-1:0]    LAST = IW'(STATES - 1);

    logic [WIDTH-1:0]  r_count;
    logic              r_wrap;
    logic              w_valid;
    logic [IW-1:0]     w_index;
    logic [STATES-1:0] w_decode;
    logic [WIDTH-1:0]  w_next;
    logic              w_wrap_step;

    // Register pattern that represents state index k.
    function automatic logic [WIDTH-1:0] state_pattern(input int k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (RING != 0)
                p[b] = (b == k);
            else if (k <= WIDTH)
                p[b] = (b < k);
            else
                p[b] = (b >= k - WIDTH);
        end
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] q);
        if (RING != 0)
            return {q[WIDTH-2:0], q[WIDTH-1]};
        else
            return {q[WIDTH-2:0], ~q[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] q);
        if (RING != 0)
            return {q[0], q[WIDTH-1:1]};
        else
            return {~q[0], q[WIDTH-1:1]};
    endfunction

    always_comb begin
        w_valid = 1'b0;
        w_index = '0;
        for (int k = 0; k < STATES; k++) begin
            if (r_count == state_pattern(k)) begin
                w_valid = 1'b1;
                w_index = IW'(k);
            end
        end
    end

    always_comb begin
        w_decode = '0;
        if (w_valid)
            w_decode[w_index] = 1'b1;
    end

    // Step from an illegal pattern still shifts, but never signals a boundary crossing.
    always_comb begin
        w_next      = Up ? step_fwd(r_count) : step_rev(r_count);
        w_wrap_step = w_valid && (Up ? (w_index == LAST) : (w_index == '0));
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_count <= SEED;
            r_wrap  <= 1'b0;
        end else if (Load) begin
            r_count <= Load_value;
            r_wrap  <= 1'b0;
        end
`ifdef SELF_CORRECT_EN
        else if (!w_valid) begin
            r_count <= SEED;
            r_wrap  <= 1'b0;
        end
`endif
        else if (Enable) begin
            r_count <= w_next;
            r_wrap  <= w_wrap_step;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign Count_out  = r_count;
    assign Decode_out = w_decode;
    assign Index_out  = w_index;
    assign Wrap       = r_wrap;
    assign Invalid    = ~w_valid;

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Bench for twisted_ring_counter: three configurations (W4 Johnson, W4 ring, W5 Johnson) on shared stimulus,
// checked against an index-based reference model.
module tb_twisted_ring_counter;

    logic       Clock = 1'b0;
    logic       Reset, Enable, Up, Load;
    logic [3:0] lv_a, lv_b;
    logic [4:0] lv_c;

    logic [3:0] cnt_a; logic [7:0] dec_a; logic [2:0] idx_a; logic wrap_a, inv_a;
    logic [3:0] cnt_b; logic [3:0] dec_b; logic [1:0] idx_b; logic wrap_b, inv_b;
    logic [4:0] cnt_c; logic [9:0] dec_c; logic [3:0] idx_c; logic wrap_c, inv_c;

    int vectors     = 0;
    int miscompares = 0;

    int          CFG_W[3] = '{4, 4, 5};
    int          CFG_R[3] = '{0, 1, 0};
    int unsigned m_val[3] = '{0, 0, 0};
    int unsigned m_wrap[3] = '{0, 0, 0};

    twisted_ring_counter #(.WIDTH(4), .RING(0)) u_a (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .Load_value(lv_a),
        .Count_out(cnt_a), .Decode_out(dec_a), .Index_out(idx_a), .Wrap(wrap_a), .Invalid(inv_a));
    twisted_ring_counter #(.WIDTH(4), .RING(1)) u_b (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .Load_value(lv_b),
        .Count_out(cnt_b), .Decode_out(dec_b), .Index_out(idx_b), .Wrap(wrap_b), .Invalid(inv_b));
    twisted_ring_counter #(.WIDTH(5), .RING(0)) u_c (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .Load_value(lv_c),
        .Count_out(cnt_c), .Decode_out(dec_c), .Index_out(idx_c), .Wrap(wrap_c), .Invalid(inv_c));

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference model: legal states are tracked as an index on a circle of nstates positions.
    function automatic int nstates(input int w, input int r);
        return (r != 0) ? w : 2 * w;
    endfunction

    function automatic int unsigned pat(input int w, input int r, input int k);
        int unsigned m;
        m = (32'd1 << w) - 1;
        if (r != 0) return 32'd1 << k;
        if (k <= w) return (32'd1 << k) - 1;
        return m & ~((32'd1 << (k - w)) - 1);
    endfunction

    function automatic int idx_of(input int w, input int r, input int unsigned v);
        for (int k = 0; k < nstates(w, r); k++)
            if (pat(w, r, k) == v) return k;
        return -1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int w, r, s, k;
            int unsigned mask, v, lvv;
            w = CFG_W[i]; r = CFG_R[i]; s = nstates(w, r);
            mask = (32'd1 << w) - 1;
            v = m_val[i];
            lvv = (i == 0) ? 32'(lv_a) : (i == 1) ? 32'(lv_b) : 32'(lv_c);
            k = idx_of(w, r, v);
            m_wrap[i] = 0;
            if (!Reset) v = (r != 0) ? 1 : 0;
            else if (Load) v = lvv;
`ifdef SELF_CORRECT_EN
            else if (k < 0) v = (r != 0) ? 1 : 0;
`endif
            else if (Enable) begin
                if (k >= 0) begin
                    m_wrap[i] = ((Up && k == s - 1) || (!Up && k == 0)) ? 1 : 0;
                    v = pat(w, r, Up ? (k + 1) % s : (k + s - 1) % s);
                end else if (Up) begin
                    v = ((v << 1) & mask) | ((r != 0) ? ((v >> (w - 1)) & 1) : (~(v >> (w - 1)) & 1));
                end else begin
                    v = (v >> 1) | (((r != 0) ? (v & 1) : (~v & 1)) << (w - 1));
                end
            end
            m_val[i] = v;
        end
    endtask

    // Expected {count, index, decode, wrap, invalid} packed for instance i.
    function automatic logic [31:0] mexp(input int i);
        int w, r, s, iw, k;
        int unsigned idx, dec, inv;
        w = CFG_W[i]; r = CFG_R[i]; s = nstates(w, r); iw = $clog2(s);
        k = idx_of(w, r, m_val[i]);
        idx = (k < 0) ? 0 : k;
        dec = (k < 0) ? 0 : (32'd1 << k);
        inv = (k < 0) ? 1 : 0;
        return (m_val[i] << (s + iw + 2)) | (idx << (s + 2)) | (dec << 2) | (m_wrap[i] << 1) | inv;
    endfunction

    function automatic logic [31:0] obs(input int i);
        case (i)
            0:       return {15'b0, cnt_a, idx_a, dec_a, wrap_a, inv_a};
            1:       return {20'b0, cnt_b, idx_b, dec_b, wrap_b, inv_b};
            default: return {11'b0, cnt_c, idx_c, dec_c, wrap_c, inv_c};
        endcase
    endfunction

    task automatic cycle();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic rst, input logic en, input logic up, input logic ld);
        Reset = rst; Enable = en; Up = up; Load = ld;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        lv_a = 4'b0101; lv_b = 4'b0110; lv_c = 5'b10101;
        cycle();
        vectors++;
        if ({cnt_a, idx_a, dec_a, wrap_a, inv_a} !== {4'b0000, 3'd0, 8'h01, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a: got %h required %h", {cnt_a, idx_a, dec_a, wrap_a, inv_a}, {4'b0000, 3'd0, 8'h01, 1'b0, 1'b0});
        end
        vectors++;
        if ({cnt_b, idx_b, dec_b, wrap_b, inv_b} !== {4'b0001, 2'd0, 4'h1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_b: got %h required %h", {cnt_b, idx_b, dec_b, wrap_b, inv_b}, {4'b0001, 2'd0, 4'h1, 1'b0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== mexp(i)) begin
                miscompares++;
                $display("FAIL reset_model inst%0d: got %h required %h", i, obs(i), mexp(i));
            end
        end
    endtask

    task automatic test_johnson_fwd();
        logic [3:0] seq [8];
        seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            cycle();
            vectors++;
            if ({cnt_a, wrap_a} !== {seq[n], (n == 7)}) begin
                miscompares++;
                $display("FAIL johnson_fwd edge%0d: got cnt=%b wrap=%b required cnt=%b wrap=%b", n + 1, cnt_a, wrap_a, seq[n], (n == 7));
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL johnson_fwd_model inst%0d edge%0d: got %h required %h", i, n + 1, obs(i), mexp(i));
                end
            end
        end
    endtask

    task automatic test_reverse();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        vectors++;
        if ({cnt_a, idx_a, dec_a, wrap_a} !== {4'b1000, 3'd7, 8'h80, 1'b1}) begin
            miscompares++;
            $display("FAIL reverse_wrap: got %h required %h", {cnt_a, idx_a, dec_a, wrap_a}, {4'b1000, 3'd7, 8'h80, 1'b1});
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        vectors++;
        if ({cnt_a, wrap_a} !== {4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL reverse_hold: got cnt=%b wrap=%b required cnt=1000 wrap=0", cnt_a, wrap_a);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== mexp(i)) begin
                miscompares++;
                $display("FAIL reverse_model inst%0d: got %h required %h", i, obs(i), mexp(i));
            end
        end
    endtask

    task automatic test_load_priority();
        lv_a = 4'b0111; lv_b = 4'b0100; lv_c = 5'b11100;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        vectors++;
        if ({cnt_a, idx_a, wrap_a, inv_a} !== {4'b0111, 3'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL load_priority: got %h required %h", {cnt_a, idx_a, wrap_a, inv_a}, {4'b0111, 3'd3, 1'b0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== mexp(i)) begin
                miscompares++;
                $display("FAIL load_model inst%0d: got %h required %h", i, obs(i), mexp(i));
            end
        end
    endtask

    task automatic test_illegal();
        lv_a = 4'b0101; lv_b = 4'b0101; lv_c = 5'b01010;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        vectors++;
        if ({inv_a, dec_a, idx_a} !== {1'b1, 8'h00, 3'd0}) begin
            miscompares++;
            $display("FAIL illegal_load: got inv=%b dec=%h idx=%0d required inv=1 dec=00 idx=0", inv_a, dec_a, idx_a);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            cycle();
            vectors++;
`ifdef SELF_CORRECT_EN
            if ({cnt_a, inv_a, wrap_a} !== {4'b0000, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL illegal_correct edge%0d: got cnt=%b inv=%b required cnt=0000 inv=0", n, cnt_a, inv_a);
            end
`else
            if ({cnt_a, inv_a, wrap_a} !== {4'b0101, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL illegal_hold edge%0d: got cnt=%b inv=%b required cnt=0101 inv=1", n, cnt_a, inv_a);
            end
`endif
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL illegal_model inst%0d edge%0d: got %h required %h", i, n, obs(i), mexp(i));
                end
            end
        end
        // An enabled step from an illegal pattern must not pulse Wrap.
        lv_a = 4'b1011; lv_b = 4'b1001; lv_c = 5'b10011;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            cycle();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL illegal_step inst%0d edge%0d: got %h required %h", i, n, obs(i), mexp(i));
                end
            end
        end
    endtask

    task automatic test_ring();
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) begin
            cycle();
            vectors++;
            if ({cnt_b, wrap_b, inv_b} !== {seq[n], (n == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL ring_fwd edge%0d: got cnt=%b wrap=%b required cnt=%b wrap=%b", n + 1, cnt_b, wrap_b, seq[n], (n == 3));
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        vectors++;
        if ({cnt_b, wrap_b, cnt_a} !== {4'b0001, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL ring_reset_mid: got cnt_b=%b wrap=%b cnt_a=%b required 0001 0 0000", cnt_b, wrap_b, cnt_a);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs(i) !== mexp(i)) begin
                miscompares++;
                $display("FAIL ring_model inst%0d: got %h required %h", i, obs(i), mexp(i));
            end
        end
    endtask

    task automatic test_w5_updown();
        int e;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, 1'b1, (n <= 10), 1'b0);
            cycle();
            e = (n <= 10) ? (n % 10) : ((20 - n) % 10);
            vectors++;
            if ({idx_c, wrap_c, inv_c} !== {4'(e), (n == 10 || n == 11), 1'b0}) begin
                miscompares++;
                $display("FAIL w5_updown edge%0d: got idx=%0d wrap=%b inv=%b required idx=%0d wrap=%b inv=0",
                         n, idx_c, wrap_c, inv_c, e, (n == 10 || n == 11));
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL w5_model inst%0d edge%0d: got %h required %h", i, n, obs(i), mexp(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            lv_a = 4'($urandom); lv_b = 4'($urandom); lv_c = 5'($urandom);
            cycle();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL random inst%0d cycle%0d: got %h required %h", i, n, obs(i), mexp(i));
                end
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        lv_a = '0; lv_b = '0; lv_c = '0;
        #1;
        test_reset();
        test_johnson_fwd();
        test_reverse();
        test_load_priority();
        test_illegal();
        test_ring();
        test_w5_updown();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
